// File: rtl/datamemory_sized.sv
// Byte-addressable MIPS data memory with byte/half/word lanes, req/ready handshake and wait states.
// Misaligned halfword/word accesses are trapped and reported instead of touching the RAM.
//
// state  | meaning
// S_IDLE | waiting for req; latches operands on acceptance
// S_WAIT | counting down wait states; access happens on the edge where the count is zero
// S_DONE | ready pulse; a new request may be accepted on the edge that ends this cycle
module datamemory_sized #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic                  ready,
  output logic                  busy,
  output logic                  misaligned
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state, nextState;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic                  weQ, sextQ, trapQ;
  logic [1:0]            sizeQ;
  logic [31:0]           dinQ;
  logic [31:0]           mem [DEPTH];

  logic        misIn, accept, doAccess;
  logic [31:0] rdWord, loadVal, wData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [3:0]  laneEn;

  assign misIn    = (size == 2'b01) ? addr[0] : (size[1] ? (addr[1:0] != 2'b00) : 1'b0);
  assign accept   = req && (state == S_IDLE || state == S_DONE);
  assign doAccess = (state == S_WAIT) && (cnt == 4'd0);

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (req) nextState = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) nextState = S_DONE;
      S_DONE:  nextState = req ? S_WAIT : S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Trapped accesses take one pass through WAIT with a zero count so they finish one edge after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      dout  <= 32'd0;
      trapQ <= 1'b0;
      addrQ <= '0;
      weQ   <= 1'b0;
      sizeQ <= 2'b00;
      sextQ <= 1'b0;
      dinQ  <= 32'd0;
    end else begin
      state <= nextState;
      if (accept) begin
        addrQ <= addr;
        weQ   <= we;
        sizeQ <= size;
        sextQ <= sign_ext;
        dinQ  <= din;
        trapQ <= misIn;
        cnt   <= misIn ? 4'd0 : 4'(WAIT_STATES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (doAccess) dout <= (weQ || trapQ) ? 32'd0 : loadVal;
    end
  end

  assign rdWord = mem[addrQ[ADDR_WIDTH-1:2]];

  always_comb begin
    byteSel = rdWord[7:0];
    case (addrQ[1:0])
      2'd0:    byteSel = rdWord[31:24];
      2'd1:    byteSel = rdWord[23:16];
      2'd2:    byteSel = rdWord[15:8];
      default: byteSel = rdWord[7:0];
    endcase
    halfSel = addrQ[1] ? rdWord[15:0] : rdWord[31:16];
    case (sizeQ)
      2'b00:   loadVal = sextQ ? {{24{byteSel[7]}}, byteSel} : {24'd0, byteSel};
      2'b01:   loadVal = sextQ ? {{16{halfSel[15]}}, halfSel} : {16'd0, halfSel};
      default: loadVal = rdWord;
    endcase
  end

  // laneEn bit k enables big-endian byte offset k, i.e. word bits [31-8k -: 8].
  always_comb begin
    case (sizeQ)
      2'b00: begin
        laneEn = 4'b0001 << addrQ[1:0];
        wData  = {4{dinQ[7:0]}};
      end
      2'b01: begin
        laneEn = addrQ[1] ? 4'b1100 : 4'b0011;
        wData  = {2{dinQ[15:0]}};
      end
      default: begin
        laneEn = 4'b1111;
        wData  = dinQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && doAccess && weQ && !trapQ) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn[k]) mem[addrQ[ADDR_WIDTH-1:2]][31-8*k -: 8] <= wData[31-8*k -: 8];
      end
    end
  end

  assign ready      = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign misaligned = ready && trapQ;

endmodule
